// File: rtl/buf64_ctrl_if.sv
// Control/address bundle for the two-bank RAM64 ping-pong buffer controller.
// master: stream source / test driver (drives ED, START, STOP).
// slave : buf64_ctrl (drives bank write enables, addresses, output-mux select,
//         valid, frame-ready pulse and busy).
interface buf64_ctrl_if;
    localparam int unsigned AW = 6;

    logic          ED;     // clock enable; low freezes the controller
    logic          START;  // frame-stream start pulse
    logic          STOP;   // stop request
    logic          WE0;    // bank 0 write enable
    logic          WE1;    // bank 1 write enable
    logic [AW-1:0] ADDR0;  // bank 0 address
    logic [AW-1:0] ADDR1;  // bank 1 address
    logic          SEL;    // bank whose DO is currently valid
    logic          OVLD;   // selected DO carries valid read data
    logic          RDY;    // pulse on output sample index 0 of each frame
    logic          BUSY;   // controller not idle

    modport master (
        output ED, START, STOP,
        input  WE0, WE1, ADDR0, ADDR1, SEL, OVLD, RDY, BUSY
    );

    modport slave (
        input  ED, START, STOP,
        output WE0, WE1, ADDR0, ADDR1, SEL, OVLD, RDY, BUSY
    );
endinterface

// File: rtl/buf64_ctrl.sv
// Ping-pong controller for two 64-entry RAM banks: one bank is filled while the
// other is read back, with write and read sharing a single 6-bit counter.
// Read order is natural (delay buffer) by default; defining BUF64_BITREV_EN
// reads each frame in bit-reversed address order.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-low reset
//   bus  - buf64_ctrl_if.slave (ED/START/STOP in; WE0/WE1, ADDR0/ADDR1,
//          SEL, OVLD, RDY, BUSY out)
// Parameter LAT (>= 1): RAM read latency in ED-qualified cycles.
// WEx, ADDRx and BUSY are decoded combinationally from registered state;
// SEL, OVLD and RDY come straight from the latency-matching delay line.
module buf64_ctrl #(
    parameter int unsigned LAT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    buf64_ctrl_if.slave   bus
);
    localparam int unsigned AW = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wcnt, wcnt_nxt;
    logic [AW-1:0] raddr;
    logic          wbank, wbank_nxt;
    logic          stop_pend, stop_nxt;
    logic          wr_act, rd_act, rbank, wrap;

    logic [LAT-1:0] dl_vld;
    logic [LAT-1:0] dl_bank;
    logic [LAT-1:0] dl_first;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            wcnt      <= '0;
            wbank     <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            wbank     <= wbank_nxt;
            stop_pend <= stop_nxt;
        end
    end

    assign wrap = (wcnt == '1);

    // Next-state logic; everything holds while ED is low
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        wbank_nxt = wbank;
        stop_nxt  = stop_pend;
        if (bus.ED) begin
            if ((state == FILL || state == STREAM) && bus.STOP) begin
                stop_nxt = 1'b1;
            end
            case (state)
                IDLE: begin
                    // A STOP arriving with START is ignored: stop_pend starts clear
                    if (bus.START) begin
                        state_nxt = FILL;
                        wcnt_nxt  = '0;
                        wbank_nxt = 1'b0;
                        stop_nxt  = 1'b0;
                    end
                end
                FILL: begin
                    wcnt_nxt = wcnt + AW'(1);
                    if (wrap) begin
                        state_nxt = STREAM;
                        wbank_nxt = ~wbank;
                    end
                end
                STREAM: begin
                    wcnt_nxt = wcnt + AW'(1);
                    if (wrap) begin
                        wbank_nxt = ~wbank;
                        state_nxt = stop_pend ? DRAIN : STREAM;
                    end
                end
                DRAIN: begin
                    wcnt_nxt = wcnt + AW'(1);
                    if (wrap) begin
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef BUF64_BITREV_EN
    // Bit-reversed read order
    always_comb begin
        raddr = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            raddr[i] = wcnt[AW-1-i];
        end
    end
`else
    // Natural read order
    assign raddr = wcnt;
`endif

    assign wr_act = (state == FILL) || (state == STREAM);
    assign rd_act = (state == STREAM) || (state == DRAIN);
    assign rbank  = ~wbank;

    assign bus.WE0  = bus.ED && wr_act && !wbank;
    assign bus.WE1  = bus.ED && wr_act && wbank;
    assign bus.BUSY = (state != IDLE);

    // Bank address mux: write address, read address, or parked at 0
    always_comb begin
        bus.ADDR0 = '0;
        bus.ADDR1 = '0;
        if (wr_act && !wbank) begin
            bus.ADDR0 = wcnt;
        end else if (rd_act && !rbank) begin
            bus.ADDR0 = raddr;
        end
        if (wr_act && wbank) begin
            bus.ADDR1 = wcnt;
        end else if (rd_act && rbank) begin
            bus.ADDR1 = raddr;
        end
    end

    // Latency-matching delay line; keeps shifting in IDLE so the tail flushes.
    // Bank is captured as 0 when no read is active so SEL idles low.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dl_vld   <= '0;
            dl_bank  <= '0;
            dl_first <= '0;
        end else if (bus.ED) begin
            for (int unsigned i = 1; i < LAT; i++) begin
                dl_vld[i]   <= dl_vld[i-1];
                dl_bank[i]  <= dl_bank[i-1];
                dl_first[i] <= dl_first[i-1];
            end
            dl_vld[0]   <= rd_act;
            dl_bank[0]  <= rd_act && rbank;
            dl_first[0] <= rd_act && (wcnt == '0);
        end
    end

    assign bus.OVLD = dl_vld[LAT-1];
    assign bus.SEL  = dl_bank[LAT-1];
    assign bus.RDY  = dl_first[LAT-1];

endmodule
